// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_PARITY_EVEN = 1'b1;

    // Expected parity bit for a data byte: even parity makes the total count of ones even.
    function automatic logic expected_parity(input logic [UART_DATA_BITS-1:0] d,
                                             input logic                      even);
        return (^d) ^ ~even;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversampling tick generator: one tick every DIV clocks, restartable by clear.
module uart_rx_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // Free-running divider; clear realigns the tick grid to the start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop bit, valid/ready output.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote around the bit centre.
// Handshake: a byte is transferred on any clock where data_valid && data_ready;
// data_out/parity_err/frame_err hold while data_valid is high and the consumer stalls.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int PW   = $clog2(OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;
    localparam int BW   = $clog2(UART_DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int DECIDE = HALF + 1;
`else
    localparam int DECIDE = HALF;
`endif

    rx_state_t state, state_n;

    logic                      rx_meta, rxs, rxs_prev;
    logic                      tick;
    logic [PW-1:0]             ph;
    logic [BW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      par_bit;
    logic                      start_det, sample_pt, bit_end, bit_val, frame_done;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    assign start_det = (state == IDLE) && rxs_prev && !rxs;
    assign sample_pt = tick && (ph == PW'(DECIDE));
    assign bit_end   = tick && (ph == PW'(OVERSAMPLE - 1));

    uart_rx_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_det),
        .tick  (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic s_a, s_b;

    // Capture the two samples that precede the deciding one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_a <= 1'b1;
            s_b <= 1'b1;
        end else if (tick) begin
            if (ph == PW'(HALF - 1)) s_a <= rxs;
            if (ph == PW'(HALF))     s_b <= rxs;
        end
    end

    assign bit_val = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
`else
    assign bit_val = rxs;
`endif

    // Bit phase, bit index and data/parity shift registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph      <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (start_det) begin
                ph <= '0;
            end else if (tick) begin
                ph <= (ph == PW'(OVERSAMPLE - 1)) ? '0 : ph + 1'b1;
            end
            if (state == IDLE) begin
                bit_idx <= '0;
            end
            if (state == DATA && sample_pt) begin
                shift   <= {bit_val, shift[UART_DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == PARITY && sample_pt) begin
                par_bit <= bit_val;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; the frame completes at the stop-bit sample point.
    always_comb begin
        state_n    = state;
        frame_done = 1'b0;
        case (state)
            IDLE:   if (start_det) state_n = START;
            START: begin
                if (sample_pt && bit_val) state_n = IDLE;
                else if (bit_end)         state_n = DATA;
            end
            DATA:   if (bit_end && bit_idx == '0) state_n = PARITY;
            PARITY: if (bit_end) state_n = STOP;
            STOP: begin
                if (sample_pt) begin
                    frame_done = 1'b1;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Output holding register with overrun detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift;
                    parity_err <= expected_parity(shift, UART_PARITY_EVEN) ^ par_bit;
                    frame_err  <= ~bit_val;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule
